// File: rtl/oqpsk_pkg.sv
// Shared types and constants for the OQPSK frame sequencer and its word FIFO.
package oqpsk_pkg;

    localparam int WORD_W    = 32;
    localparam int FLEN_W    = 8;
    localparam int PAY_CNT_W = 13;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        PAY,
        TAIL,
        DONE
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/oqpsk_word_fifo.sv
// Show-ahead synchronous word FIFO; rd_data always presents the oldest stored word.
module oqpsk_word_fifo
    import oqpsk_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              push,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              pop,
    output logic [WORD_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: storage is deliberately left unreset; pointers and count alone say what is valid.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/oqpsk_frame_sequencer.sv
// Frame sequencer feeding the OQPSK modulator: preamble, MSB-first payload words, zero tail.
module oqpsk_frame_sequencer
    import oqpsk_pkg::*;
#(
    parameter int BIT_DIV    = 8,
    parameter int PRE_LEN    = 16,
    parameter int TAIL_LEN   = 12,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [FLEN_W-1:0] frame_len,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              EN,
    output logic              BitIn,
    output logic              busy,
    output logic              done,
    output logic              underrun
);

    localparam int DIV_W = $clog2(BIT_DIV);
    localparam int BC_W  = $clog2(max_int(PRE_LEN, TAIL_LEN) + 1);

    state_t               state;
    logic [DIV_W-1:0]     div;
    logic [BC_W-1:0]      bit_cnt;
    logic [PAY_CNT_W-1:0] pay_cnt;
    logic [FLEN_W-1:0]    flen_q;
    logic [WORD_W-1:0]    shreg;

    logic                 strobe;
    logic                 word_last;
    logic                 frame_last;
    logic                 pop_need;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [WORD_W-1:0]    fifo_rd_data;

    oqpsk_word_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .CLK    (CLK),
        .RST    (RST),
        .push   (word_valid),
        .wr_data(word_data),
        .pop    (fifo_pop),
        .rd_data(fifo_rd_data),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign word_ready = !fifo_full;
    assign strobe     = (div == DIV_W'(BIT_DIV - 1));
    assign word_last  = (pay_cnt[4:0] == 5'd31);
    assign frame_last = word_last && (pay_cnt[PAY_CNT_W-1:5] == flen_q - FLEN_W'(1));

    // A pop that finds the FIFO empty becomes an underrun instead; a same-cycle push is too late.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        pop_need = 1'b0;
        if (strobe) begin
            case (state)
                PRE:     pop_need = (bit_cnt == BC_W'(PRE_LEN - 1)) && (flen_q != '0);
                PAY:     pop_need = word_last && !frame_last;
                default: pop_need = 1'b0;
            endcase
        end
        fifo_pop = pop_need && !fifo_empty;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            div      <= '0;
            bit_cnt  <= '0;
            pay_cnt  <= '0;
            flen_q   <= '0;
            shreg    <= '0;
            EN       <= 1'b0;
            BitIn    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (state inside {PRE, PAY, TAIL}) div <= strobe ? '0 : div + DIV_W'(1);
            else                               div <= '0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= PRE;
                        flen_q   <= frame_len;
                        bit_cnt  <= '0;
                        pay_cnt  <= '0;
                        EN       <= 1'b1;
                        BitIn    <= 1'b1;
                        busy     <= 1'b1;
                        underrun <= 1'b0;
                    end
                end

                PRE: begin
                    if (strobe) begin
                        if (bit_cnt == BC_W'(PRE_LEN - 1)) begin
                            bit_cnt <= '0;
                            if (flen_q == '0 || fifo_empty) begin
                                if (flen_q != '0) underrun <= 1'b1;
                                state <= TAIL;
                                BitIn <= 1'b0;
                            end else begin
                                state <= PAY;
                                shreg <= fifo_rd_data;
                                BitIn <= fifo_rd_data[WORD_W-1];
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BC_W'(1);
                            // Next index is odd exactly when the current one is even.
                            BitIn   <= bit_cnt[0];
                        end
                    end
                end

                PAY: begin
                    if (strobe) begin
                        pay_cnt <= pay_cnt + PAY_CNT_W'(1);
                        if (frame_last) begin
                            state <= TAIL;
                            BitIn <= 1'b0;
                        end else if (word_last) begin
                            if (fifo_empty) begin
                                underrun <= 1'b1;
                                state    <= TAIL;
                                BitIn    <= 1'b0;
                            end else begin
                                shreg <= fifo_rd_data;
                                BitIn <= fifo_rd_data[WORD_W-1];
                            end
                        end else begin
                            shreg <= {shreg[WORD_W-2:0], shreg[WORD_W-1]};
                            BitIn <= shreg[WORD_W-2];
                        end
                    end
                end

                TAIL: begin
                    if (strobe) begin
                        if (bit_cnt == BC_W'(TAIL_LEN - 1)) begin
                            bit_cnt <= '0;
                            state   <= DONE;
                            EN      <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BC_W'(1);
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oqpsk_frame_sequencer.sv
// Directed bench: table of whole-frame scenarios plus a hand-written mid-frame reset sequence.
module tb_oqpsk_frame_sequencer;

    localparam int BIT_DIV  = 8;
    localparam int PRE_LEN  = 16;
    localparam int TAIL_LEN = 12;
    localparam int NVEC     = 6;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [7:0]  frame_len;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic        EN;
    logic        BitIn;
    logic        busy;
    logic        done;
    logic        underrun;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_q [$];
    bit          exp_bits [$];

    typedef struct {
        string            name;
        int               flen;
        bit               stream;
        int               nw;
        logic [3:0][31:0] w;
        int               rp;
        int               exp_en;
        bit               exp_ur;
        int               exp_ready;
        int               exp_bp;
    } vec_t;

    vec_t tbl [NVEC];

    oqpsk_frame_sequencer #(
        .BIT_DIV   (BIT_DIV),
        .PRE_LEN   (PRE_LEN),
        .TAIL_LEN  (TAIL_LEN),
        .FIFO_DEPTH(2)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .frame_len (frame_len),
        .word_data (word_data),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .EN        (EN),
        .BitIn     (BitIn),
        .busy      (busy),
        .done      (done),
        .underrun  (underrun)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input int flen, input bit stream, input int nw,
                                input logic [3:0][31:0] w, input int rp, input int exp_en,
                                input bit exp_ur, input int exp_ready, input int exp_bp);
        vec_t v;
        v.name = name; v.flen = flen; v.stream = stream; v.nw = nw; v.w = w; v.rp = rp;
        v.exp_en = exp_en; v.exp_ur = exp_ur; v.exp_ready = exp_ready; v.exp_bp = exp_bp;
        return v;
    endfunction

    // Expected bit stream: alternating preamble, queued words MSB-first until one is missing, zero tail.
    task automatic build_exp(input int flen);
        logic [31:0] d;
        exp_bits.delete();
        for (int i = 0; i < PRE_LEN; i++) exp_bits.push_back(i % 2 == 0);
        for (int k = 0; k < flen; k++) begin
            if (model_q.size() == 0) break;
            d = model_q.pop_front();
            for (int b = 31; b >= 0; b--) exp_bits.push_back(d[b]);
        end
        for (int i = 0; i < TAIL_LEN; i++) exp_bits.push_back(1'b0);
    endtask

    // Entered and left on a falling edge; a word is taken at the rising edge after ready is seen.
    task automatic push_words(input logic [3:0][31:0] w, input int n, output bit waited);
        int t;
        waited = 1'b0;
        word_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            word_data = w[i];
            t = 0;
            while (!word_ready && t < 5000) begin
                waited = 1'b1;
                @(negedge CLK);
                t++;
            end
            if (t >= 5000) check("push_ready_timeout", {31'd0, word_ready}, 32'd1);
            @(negedge CLK);
        end
        word_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int en_cnt, bad, dones, idx;
        bit finished, first_ok, ur0, saw_wait;
        en_cnt = 0; bad = 0; dones = 0; finished = 0; first_ok = 0; ur0 = 0; saw_wait = 0;
        for (int i = 0; i < v.nw; i++) model_q.push_back(v.w[i]);
        build_exp(v.flen);
        if (!v.stream) push_words(v.w, v.nw, saw_wait);
        fork
            begin
                if (v.stream) push_words(v.w, v.nw, saw_wait);
            end
            begin
                start = 1'b1;
                frame_len = 8'(v.flen);
                @(negedge CLK);
                start = 1'b0;
                for (int c = 0; c < 4000; c++) begin
                    if (c == 0) begin
                        first_ok = EN && BitIn && busy;
                        ur0 = underrun;
                    end
                    start = (c == v.rp);
                    if (c == v.rp) frame_len = 8'd7;
                    if (EN) begin
                        idx = en_cnt / BIT_DIV;
                        if (idx >= exp_bits.size() || BitIn !== exp_bits[idx]) bad++;
                        en_cnt++;
                    end
                    if (done) dones++;
                    if (!busy) begin
                        finished = 1'b1;
                        break;
                    end
                    @(negedge CLK);
                end
                start = 1'b0;
            end
        join
        check($sformatf("%s first_cycle", v.name), {31'd0, first_ok}, 32'd1);
        check($sformatf("%s underrun_cleared", v.name), {31'd0, ur0}, 32'd0);
        check($sformatf("%s finished", v.name), {31'd0, finished}, 32'd1);
        check($sformatf("%s en_cycles", v.name), en_cnt, v.exp_en);
        check($sformatf("%s bit_errors", v.name), bad, 0);
        check($sformatf("%s done_pulses", v.name), dones, 1);
        check($sformatf("%s underrun", v.name), {31'd0, underrun}, {31'd0, v.exp_ur});
        if (v.exp_ready >= 0)
            check($sformatf("%s ready_after", v.name), {31'd0, word_ready}, v.exp_ready);
        if (v.exp_bp >= 0)
            check($sformatf("%s backpressure", v.name), {31'd0, saw_wait}, v.exp_bp);
    endtask

    initial begin
        bit w_unused;
        tbl[0] = mk("one_word",   1, 1'b0, 1, {32'h0, 32'h0, 32'h0, 32'hA5000000}, -1, 480, 1'b0, 1, -1);
        tbl[1] = mk("zero_len",   0, 1'b0, 2, {32'h0, 32'h0, 32'h9ABCDEF0, 32'h12345678}, -1, 224, 1'b0, 0, -1);
        tbl[2] = mk("drain_two",  2, 1'b0, 0, {32'h0, 32'h0, 32'h0, 32'h0}, -1, 736, 1'b0, 1, -1);
        tbl[3] = mk("underrun",   3, 1'b0, 2, {32'h0, 32'h0, 32'h0F0F00FF, 32'hDEADBEEF}, -1, 736, 1'b1, 1, -1);
        tbl[4] = mk("stream4",    4, 1'b1, 4, {32'h80000001, 32'h13579BDF, 32'hFFFF0000, 32'h6DB6DB6D}, -1, 1248, 1'b0, 1, 1);
        tbl[5] = mk("restart_ign", 1, 1'b0, 1, {32'h0, 32'h0, 32'h0, 32'hC3C3C3C3}, 200, 480, 1'b0, 1, -1);

        RST = 1'b0; start = 1'b0; frame_len = '0; word_data = '0; word_valid = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_state", {26'd0, EN, BitIn, busy, done, underrun, word_ready}, 32'h1);
        RST = 1'b1;
        @(negedge CLK);
        check("post_rst_state", {26'd0, EN, BitIn, busy, done, underrun, word_ready}, 32'h1);

        for (int i = 0; i < NVEC; i++) run_vec(tbl[i]);

        // Mid-payload reset with a full FIFO, then a clean frame afterwards.
        model_q.delete();
        push_words({32'h0, 32'h0, 32'h22222222, 32'h11111111}, 2, w_unused);
        start = 1'b1; frame_len = 8'd1;
        @(negedge CLK);
        start = 1'b0;
        repeat (200) @(negedge CLK);
        check("mid_busy_en", {30'd0, busy, EN}, 32'h3);
        push_words({32'h0, 32'h0, 32'h0, 32'h33333333}, 1, w_unused);
        check("full_before_rst", {31'd0, word_ready}, 32'd0);
        #2 RST = 1'b0;
        #1 check("async_rst_outputs", {27'd0, EN, BitIn, busy, done, underrun}, 32'h0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("ready_after_rst", {31'd0, word_ready}, 32'd1);
        run_vec(tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
